// File: rtl/scan_encoder_n_to_log_if.sv
// Handshake bundle for scan_encoder_n_to_log: vector in, one binary index out per handshake.
// master = producer/consumer side, slave = the encoder.
interface scan_encoder_n_to_log_if #(
  parameter int N = 32
) ();
  localparam int IW = $clog2(N);

  logic [N-1:0]  in;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] out;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          none;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid, out_last, none
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid, out_last, none
  );
endinterface

// File: rtl/scan_encoder_n_to_log.sv
// Multi-hot to binary scanner: first index one cycle after accept, one index per cycle, lowest first.
// Backpressure on out_ready holds pending/out stable; ena=0 freezes all state and blocks both handshakes.
module scan_encoder_n_to_log #(
  parameter int N = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  scan_encoder_n_to_log_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic          none_q, none_d;

  logic [IW-1:0] low_idx;
  logic [N-1:0]  pending_clr;
  logic          single_bit;
  logic          in_hs, out_hs;

  // Priority encoder: the last assignment wins, so scanning downwards leaves the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IW'(i);
    end
  end

  assign pending_clr = pending_q & (pending_q - {{(N-1){1'b0}}, 1'b1});
  assign single_bit  = (pending_q != '0) && (pending_clr == '0);

  assign bus.in_ready  = ena && (state_q == IDLE);
  assign bus.out_valid = ena && (state_q == SCAN);
  assign bus.out       = bus.out_valid ? low_idx : '0;
  assign bus.out_last  = bus.out_valid && single_bit;
  assign bus.none      = none_q;

  assign in_hs  = bus.in_valid && bus.in_ready;
  assign out_hs = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = 1'b0;
    if (in_hs) begin
      if (bus.in != '0) begin
        pending_d = bus.in;
        state_d   = SCAN;
      end else begin
        none_d = 1'b1;
      end
    end
    if (out_hs) begin
      pending_d = pending_clr;
      if (single_bit) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end
endmodule
